// File: rtl/pss_gen_pkg.sv
// pss_gen_pkg: shared constants, state type and offset helper for the NR PSS generator.
package pss_gen_pkg;
  localparam int PSS_LEN = 127;
  localparam logic [6:0] LFSR_INIT = 7'b1110110;
  localparam int TAP_A = 0;
  localparam int TAP_B = 4;
  localparam logic [6:0] NID_STEP = 7'd43;
  typedef enum logic [1:0] {IDLE, SEEK, RUN} state_e;
  function automatic logic [6:0] seek_len(input logic [1:0] nid);
    return nid == 2'd0 ? 7'd0 : nid == 2'd1 ? NID_STEP : NID_STEP << 1;
  endfunction
endpackage

// File: rtl/pss_lfsr.sv
// pss_lfsr: 7-bit Fibonacci LFSR, bit 0 is the current x(i), bit 6 is x(i+6).
module pss_lfsr
  import pss_gen_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic step_i,
  output logic x_o
);
  logic [6:0] sr_q, sr_d;
  always_comb sr_d = load_i ? LFSR_INIT : step_i ? {sr_q[TAP_B] ^ sr_q[TAP_A], sr_q[6:1]} : sr_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sr_q <= LFSR_INIT;
    else sr_q <= sr_d;
  end
  assign x_o = sr_q[0];
endmodule

// File: rtl/pss_gen.sv
// pss_gen: streams one 127-sample BPSK NR PSS per start request over AXI-Stream.
// Define PSS_GEN_INDEX_EN to add m_axis_out_tuser carrying the sample index.
module pss_gen
  import pss_gen_pkg::*;
#(
  parameter int OUT_DW = 32,
  parameter logic signed [15:0] AMP = 16'sd8192
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        N_id_2_i,
  output logic              busy_o,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast
`ifdef PSS_GEN_INDEX_EN
  ,
  output logic [6:0]        m_axis_out_tuser
`endif
);
  localparam int H = OUT_DW / 2;
  localparam logic signed [H-1:0] AMP_W = H'(AMP);
  state_e state_q, state_d;
  logic [6:0] off_q, off_d, cnt_q, cnt_d;
  logic load, step, x, run, last;
  logic signed [H-1:0] re;
  assign run = state_q == RUN;
  assign last = cnt_q == 7'(PSS_LEN - 1);
  always_comb begin
    state_d = state_q;
    off_d = off_q;
    cnt_d = cnt_q;
    load = 1'b0;
    step = 1'b0;
    case (state_q)
      IDLE: if (start_i && N_id_2_i != 2'd3) begin
        load = 1'b1;
        off_d = seek_len(N_id_2_i);
        cnt_d = '0;
        state_d = N_id_2_i == 2'd0 ? RUN : SEEK;
      end
      SEEK: begin
        step = 1'b1;
        off_d = off_q - 7'd1;
        state_d = off_q == 7'd1 ? RUN : SEEK;
      end
      RUN: if (m_axis_out_tready) begin
        step = 1'b1;
        cnt_d = last ? 7'd0 : cnt_q + 7'd1;
        state_d = last ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      off_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      cnt_q <= cnt_d;
    end
  end
  pss_lfsr u_lfsr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (load),
    .step_i (step),
    .x_o    (x)
  );
  // outputs derive from the registered state so reset clears them asynchronously
  assign re = x ? -AMP_W : AMP_W;
  assign m_axis_out_tdata = run ? {{(OUT_DW - H){1'b0}}, re} : '0;
  assign m_axis_out_tvalid = run;
  assign m_axis_out_tlast = run && last;
  assign busy_o = state_q != IDLE;
`ifdef PSS_GEN_INDEX_EN
  assign m_axis_out_tuser = run ? cnt_q : '0;
`endif
endmodule

// File: tb/tb_pss_gen.sv
// tb_pss_gen: randomized-ready directed checks of pss_gen against an m-sequence reference model.
module tb_pss_gen;
  localparam int AMP = 8192;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic start_i = 1'b0;
  logic [1:0] N_id_2_i = 2'd0;
  logic busy_o;
  logic [31:0] m_axis_out_tdata;
  logic m_axis_out_tvalid;
  logic m_axis_out_tready = 1'b1;
  logic m_axis_out_tlast;
`ifdef PSS_GEN_INDEX_EN
  logic [6:0] m_axis_out_tuser;
`endif
  int total = 0;
  int bad = 0;
  int x_ref[127];

  pss_gen dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .N_id_2_i         (N_id_2_i),
    .busy_o           (busy_o),
    .m_axis_out_tdata (m_axis_out_tdata),
    .m_axis_out_tvalid(m_axis_out_tvalid),
    .m_axis_out_tready(m_axis_out_tready),
    .m_axis_out_tlast (m_axis_out_tlast)
`ifdef PSS_GEN_INDEX_EN
    ,
    .m_axis_out_tuser (m_axis_out_tuser)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_data(input int nid, input int n);
    logic [15:0] r;
    r = x_ref[(n + 43 * nid) % 127] != 0 ? 16'(-AMP) : 16'(AMP);
    return longint'({16'h0000, r});
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_tvalid"}, longint'(m_axis_out_tvalid), 0);
    chk({tag, "_tlast"}, longint'(m_axis_out_tlast), 0);
    chk({tag, "_tdata"}, longint'(m_axis_out_tdata), 0);
    chk({tag, "_busy"}, longint'(busy_o), 0);
`ifdef PSS_GEN_INDEX_EN
    chk({tag, "_tuser"}, longint'(m_axis_out_tuser), 0);
`endif
  endtask

  // Called at a negedge; leaves the bench at a negedge (or with reset_i high on abort).
  task automatic burst(input int nid, input bit rnd, input bit poke, input int abort_at);
    int lat, idx, cyc, sum;
    logic [31:0] prev;
    bit stalled, poked;
    start_i = 1'b1;
    N_id_2_i = 2'(nid);
    m_axis_out_tready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 1;
    while (!m_axis_out_tvalid && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    chk($sformatf("latency_n%0d", nid), lat, 1 + 43 * nid);
    idx = 0; cyc = 0; sum = 0; stalled = 0; poked = 0; prev = '0;
    while (idx < 127 && cyc < 3000) begin
      cyc++;
      start_i = 1'b0;
      if (idx == abort_at) begin
        #2 reset_i = 1'b1;
        #1 idle_chk("abort_run");
        return;
      end
      chk("tvalid", longint'(m_axis_out_tvalid), 1);
      chk($sformatf("tdata_n%0d_s%0d", nid, idx), longint'(m_axis_out_tdata), exp_data(nid, idx));
      if (stalled) chk("stall_stable", longint'(m_axis_out_tdata), longint'(prev));
      chk("tlast", longint'(m_axis_out_tlast), longint'(idx == 126));
      chk("busy", longint'(busy_o), 1);
`ifdef PSS_GEN_INDEX_EN
      chk("tuser", longint'(m_axis_out_tuser), idx);
`endif
      if (poke && idx == 60 && !poked) begin
        start_i = 1'b1;
        N_id_2_i = 2'((nid + 1) % 3);
        poked = 1;
      end
      m_axis_out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev = m_axis_out_tdata;
      stalled = !m_axis_out_tready;
      if (m_axis_out_tready) begin
        sum += int'($signed(m_axis_out_tdata[15:0]));
        idx++;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    m_axis_out_tready = 1'b1;
    chk($sformatf("handshakes_n%0d", nid), idx, 127);
    chk($sformatf("sum_n%0d", nid), sum, -AMP);
    idle_chk("post_burst");
  endtask

  initial begin
    int seek_cycles;
    x_ref[0:6] = '{0, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 120; i++) x_ref[i + 7] = x_ref[i + 4] ^ x_ref[i];
    @(negedge clk_i);
    idle_chk("reset");
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    idle_chk("idle");
    burst(0, 0, 0, -1);
    chk("first_reals", longint'({exp_data(0, 0) == 64'h2000, exp_data(0, 1) == 64'hE000,
                                 exp_data(0, 2) == 64'hE000, exp_data(0, 3) == 64'h2000}), 15);
    @(negedge clk_i);
    burst(1, 0, 0, -1);
    @(negedge clk_i);
    burst(2, 0, 0, -1);
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      burst(k, 1, 0, -1);
      @(negedge clk_i);
    end
    burst(1, 1, 1, -1);
    @(negedge clk_i);
    start_i = 1'b1;
    N_id_2_i = 2'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    idle_chk("illegal_nid");
    @(negedge clk_i);
    idle_chk("illegal_nid_later");
    start_i = 1'b1;
    N_id_2_i = 2'd2;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    seek_cycles = 0;
    repeat (20) begin
      @(negedge clk_i);
      seek_cycles++;
    end
    chk("seek_busy", longint'(busy_o), 1);
    chk("seek_tvalid", longint'(m_axis_out_tvalid), 0);
    #2 reset_i = 1'b1;
    #1 idle_chk("abort_seek");
    @(negedge clk_i);
    reset_i = 1'b0;
    burst(1, 1, 0, -1);
    @(negedge clk_i);
    burst(0, 1, 0, 30);
    @(negedge clk_i);
    idle_chk("held_reset");
    reset_i = 1'b0;
    burst(2, 1, 0, -1);
    @(negedge clk_i);
    idle_chk("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
